// File: rtl/t07_mem_arb_pkg.sv
// Shared types and constants for the t07 multi-channel memory arbiter.
package t07_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } t07_arb_state_t;

  // External port command encoding; 2'b11 is never driven.
  localparam logic [1:0] RWI_IDLE  = 2'b00;
  localparam logic [1:0] RWI_READ  = 2'b01;
  localparam logic [1:0] RWI_WRITE = 2'b10;

  // Arbitration policies.
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Map a latched write-enable onto the external command encoding.
  function automatic logic [1:0] rwi_for(input logic we);
    return we ? RWI_WRITE : RWI_READ;
  endfunction

endpackage

// File: rtl/t07_rr_arbiter.sv
// Combinational request arbiter: round-robin from a start pointer, or fixed
// priority (lowest index wins) when ARB_MODE selects it.
module t07_rr_arbiter
  import t07_mem_arb_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int ARB_MODE = ARB_RR,
  parameter int PW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [PW-1:0]  idx
);

  logic [PW-1:0] base_s;
  logic [PW:0]   sum_s;
  logic [PW-1:0] cand_s;
  logic          found_s;

  // Walk the channels starting at the base, wrapping at NCH-1, first hit wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    if (ARB_MODE == ARB_FIXED) begin
      base_s = '0;
    end else begin
      base_s = ptr;
    end
    for (int k = 0; k < NCH; k++) begin
      sum_s = {1'b0, base_s} + (PW+1)'(k);
      if (sum_s >= (PW+1)'(NCH)) begin
        sum_s = sum_s - (PW+1)'(NCH);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[PW-1:0];
      if (!found_s && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        idx           = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/t07_mem_arbiter.sv
// t07 memory arbiter: NCH requesters share one busy-handshake external port.
// Owns arbitration, request latching, busy timeout and error reporting.
module t07_mem_arbiter
  import t07_mem_arb_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ARB_MODE    = ARB_RR,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      req_i,
  input  logic [NCH-1:0]      we_i,
  input  logic [NCH*AW-1:0]   addr_i,
  input  logic [NCH*DW-1:0]   wdata_i,
  input  logic [NCH*DW/8-1:0] strb_i,
  output logic [NCH-1:0]      done_o,
  output logic [DW-1:0]       rdata_o,
  output logic [NCH-1:0]      freeze_o,
  output logic                err_o,
  output logic                err_sticky_o,
  output logic [1:0]          ext_rwi_o,
  output logic [AW-1:0]       ext_addr_o,
  output logic [DW-1:0]       ext_wdata_o,
  output logic [DW/8-1:0]     ext_strb_o,
  input  logic [DW-1:0]       ext_rdata_i,
  input  logic                ext_busy_i
);

  localparam int SW = DW / 8;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  t07_arb_state_t state_r, state_next_s;

  logic [NCH-1:0] arb_gnt_s;
  logic [PW-1:0]  arb_idx_s;
  logic [NCH-1:0] gnt_r;
  logic [PW-1:0]  idx_r;
  logic [PW-1:0]  ptr_r;
  logic           we_r;
  logic [AW-1:0]  addr_r;
  logic [DW-1:0]  wdata_r;
  logic [SW-1:0]  strb_r;
  logic [CW-1:0]  cnt_r;
  logic [1:0]     rwi_r;
  logic [NCH-1:0] done_r;
  logic           err_r;
  logic           err_sticky_r;
  logic [DW-1:0]  rdata_r;
  logic           win_we_s;
  logic [AW-1:0]  win_addr_s;
  logic [DW-1:0]  win_wdata_s;
  logic [SW-1:0]  win_strb_s;
  logic           timeout_s;
  logic           cnt_last_s;
  logic           active_next_s;

  t07_rr_arbiter #(
    .NCH      (NCH),
    .ARB_MODE (ARB_MODE),
    .PW       (PW)
  ) u_arb (
    .req   (req_i),
    .ptr   (ptr_r),
    .grant (arb_gnt_s),
    .idx   (arb_idx_s)
  );

  // One-hot mux of the winning channel's command fields.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    win_strb_s  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (arb_gnt_s[c]) begin
        win_we_s    = we_i[c];
        win_addr_s  = addr_i[c*AW +: AW];
        win_wdata_s = wdata_i[c*DW +: DW];
        win_strb_s  = strb_i[c*SW +: SW];
      end else begin
        win_we_s = win_we_s;
      end
    end
  end

  // Next-state logic; a normal busy release wins over a coincident timeout.
  always_comb begin
    state_next_s = state_r;
    timeout_s    = 1'b0;
    cnt_last_s   = (cnt_r == CW'(TIMEOUT_CYC - 1));
    case (state_r)
      ST_IDLE: begin
        if (|req_i) state_next_s = ST_ISSUE;
        else        state_next_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (cnt_last_s) begin
          state_next_s = ST_RESP;
          timeout_s    = 1'b1;
        end else if (ext_busy_i) begin
          state_next_s = ST_WAIT_DONE;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (!ext_busy_i) begin
          state_next_s = ST_RESP;
        end else if (cnt_last_s) begin
          state_next_s = ST_RESP;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = ST_WAIT_DONE;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
    active_next_s = (state_next_s == ST_ISSUE) || (state_next_s == ST_WAIT_DONE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Latch the winner's command when leaving IDLE; these also drive the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r   <= '0;
      idx_r   <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      strb_r  <= '0;
    end else if (state_r == ST_IDLE && |req_i) begin
      gnt_r   <= arb_gnt_s;
      idx_r   <= arb_idx_s;
      we_r    <= win_we_s;
      addr_r  <= win_addr_s;
      wdata_r <= win_wdata_s;
      strb_r  <= win_strb_s;
    end else begin
      gnt_r   <= gnt_r;
      idx_r   <= idx_r;
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      strb_r  <= strb_r;
    end
  end

  // Timeout counter: zero outside a transaction, counts in ISSUE/WAIT_DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == ST_ISSUE || state_r == ST_WAIT_DONE) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // Registered port command, completion pulse, read data and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rwi_r        <= RWI_IDLE;
      done_r       <= '0;
      err_r        <= 1'b0;
      err_sticky_r <= 1'b0;
      rdata_r      <= '0;
    end else begin
      if (active_next_s) rwi_r <= rwi_for((state_r == ST_IDLE) ? win_we_s : we_r);
      else               rwi_r <= RWI_IDLE;
      done_r       <= (state_next_s == ST_RESP) ? gnt_r : '0;
      err_r        <= timeout_s;
      err_sticky_r <= err_sticky_r | timeout_s;
      rdata_r      <= (state_next_s == ST_RESP && !timeout_s && !we_r) ? ext_rdata_i : '0;
    end
  end

  // Round-robin pointer advances past the served channel in RESP only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (state_r == ST_RESP) begin
      ptr_r <= (idx_r == PW'(NCH - 1)) ? '0 : idx_r + PW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign done_o       = done_r;
  assign rdata_o      = rdata_r;
  assign freeze_o     = req_i & ~done_r;
  assign err_o        = err_r;
  assign err_sticky_o = err_sticky_r;
  assign ext_rwi_o    = rwi_r;
  assign ext_addr_o   = addr_r;
  assign ext_wdata_o  = wdata_r;
  assign ext_strb_o   = strb_r;

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Directed bench for t07_mem_arbiter: a round-robin instance with a short
// timeout and a fixed-priority instance, driven by hand-computed vectors.
module tb_t07_mem_arbiter;
  import t07_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic [2:0]  a_req, a_we, a_done, a_freeze;
  logic [95:0] a_addr, a_wdata;
  logic [11:0] a_strb;
  logic [31:0] a_rdata, a_eaddr, a_ewdata, a_erdata;
  logic [3:0]  a_estrb;
  logic [1:0]  a_rwi;
  logic        a_err, a_sticky, a_busy;

  logic [2:0]  b_req, b_we, b_done, b_freeze;
  logic [95:0] b_addr, b_wdata;
  logic [11:0] b_strb;
  logic [31:0] b_rdata, b_eaddr, b_ewdata, b_erdata;
  logic [3:0]  b_estrb;
  logic [1:0]  b_rwi;
  logic        b_err, b_sticky, b_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  t07_mem_arbiter #(.NCH(3), .AW(32), .DW(32), .ARB_MODE(ARB_RR), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .rst(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .strb_i(a_strb), .done_o(a_done), .rdata_o(a_rdata),
    .freeze_o(a_freeze), .err_o(a_err), .err_sticky_o(a_sticky), .ext_rwi_o(a_rwi),
    .ext_addr_o(a_eaddr), .ext_wdata_o(a_ewdata), .ext_strb_o(a_estrb),
    .ext_rdata_i(a_erdata), .ext_busy_i(a_busy)
  );

  t07_mem_arbiter #(.NCH(3), .AW(32), .DW(32), .ARB_MODE(ARB_FIXED), .TIMEOUT_CYC(255)) dut_b (
    .clk(clk), .rst(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .strb_i(b_strb), .done_o(b_done), .rdata_o(b_rdata),
    .freeze_o(b_freeze), .err_o(b_err), .err_sticky_o(b_sticky), .ext_rwi_o(b_rwi),
    .ext_addr_o(b_eaddr), .ext_wdata_o(b_ewdata), .ext_strb_o(b_estrb),
    .ext_rdata_i(b_erdata), .ext_busy_i(b_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) for a command on port A, ack it for one cycle, return done.
  task automatic serve_a(input logic [31:0] rd, output logic [2:0] d,
                         output logic [2:0] fr, output logic [31:0] ea);
    int n = 0;
    while (a_rwi == RWI_IDLE && n < 20) begin step(); n++; end
    check_eq("a_issue_seen", 32'(n < 20), 32'd1);
    ea = a_eaddr;
    fr = a_freeze;
    a_busy = 1'b1; step();
    a_busy = 1'b0; a_erdata = rd; step();
    d = a_done;
  endtask

  // Same handshake on port B.
  task automatic serve_b(input logic [31:0] rd, output logic [2:0] d, output logic [2:0] fr);
    int n = 0;
    while (b_rwi == RWI_IDLE && n < 20) begin step(); n++; end
    check_eq("b_issue_seen", 32'(n < 20), 32'd1);
    fr = b_freeze;
    b_busy = 1'b1; step();
    b_busy = 1'b0; b_erdata = rd; step();
    d = b_done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  d, fr;
    logic [31:0] ea;
    logic [2:0]  rr_exp [4];
    int          rr_idx [4];
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_idx = '{0, 1, 2, 0};

    rst = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_strb = '0; a_erdata = '0; a_busy = 1'b0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_strb = '0; b_erdata = '0; b_busy = 1'b0;
    step(); step();

    // Reset state
    check_eq("rst_rwi",    32'(a_rwi),    32'h0);
    check_eq("rst_done",   32'(a_done),   32'h0);
    check_eq("rst_rdata",  a_rdata,       32'h0);
    check_eq("rst_err",    32'(a_err),    32'h0);
    check_eq("rst_sticky", 32'(a_sticky), 32'h0);
    check_eq("rst_addr",   a_eaddr,       32'h0);
    check_eq("rst_strb",   32'(a_estrb),  32'h0);
    rst = 1'b0;
    step();

    // Read on ch1: busy high at k+2, low at k+3, done in k+4
    a_req = 3'b010; a_we = 3'b000; a_addr[32 +: 32] = 32'h0000_0100;
    step();
    check_eq("rd_rwi_k1",  32'(a_rwi),    32'h1);
    check_eq("rd_addr",    a_eaddr,       32'h0000_0100);
    check_eq("rd_freeze",  32'(a_freeze), 32'h2);
    check_eq("rd_done_k1", 32'(a_done),   32'h0);
    step();
    check_eq("rd_rwi_k2",  32'(a_rwi),    32'h1);
    a_busy = 1'b1;
    step();
    check_eq("rd_rwi_k3",  32'(a_rwi),    32'h1);
    check_eq("rd_done_k3", 32'(a_done),   32'h0);
    a_busy = 1'b0; a_erdata = 32'hDEAD_BEEF;
    step();
    check_eq("rd_done",    32'(a_done),   32'h2);
    check_eq("rd_rdata",   a_rdata,       32'hDEAD_BEEF);
    check_eq("rd_rwi_resp", 32'(a_rwi),   32'h0);
    check_eq("rd_err",     32'(a_err),    32'h0);
    check_eq("rd_freeze_done", 32'(a_freeze), 32'h0);
    a_req = 3'b000;
    step();
    check_eq("rd_done_clr", 32'(a_done),  32'h0);

    // Write on ch2 with busy already high when ISSUE is entered
    a_req = 3'b100; a_we = 3'b100; a_wdata[64 +: 32] = 32'h1234_5678; a_strb[8 +: 4] = 4'b0011;
    a_busy = 1'b1;
    step();
    check_eq("wr_rwi",   32'(a_rwi),   32'h2);
    check_eq("wr_strb",  32'(a_estrb), 32'h3);
    check_eq("wr_wdata", a_ewdata,     32'h1234_5678);
    step();
    a_busy = 1'b0; a_erdata = 32'hCAFE_F00D;
    step();
    check_eq("wr_done",  32'(a_done),  32'h4);
    check_eq("wr_rdata", a_rdata,      32'h0);
    a_req = 3'b000; a_we = 3'b000;
    step();

    // Round-robin with all channels requesting; pointer is back at 0
    a_addr = {32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
    a_req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      serve_a(32'h0000_0100 + 32'(i), d, fr, ea);
      check_eq("rr_done",   32'(d),  32'(rr_exp[i]));
      check_eq("rr_addr",   ea,      32'h0000_1000 + 32'(4 * rr_idx[i]));
      check_eq("rr_freeze", 32'(fr), 32'h7);
      check_eq("rr_freeze_done", 32'(a_freeze), 32'(3'b111 & ~rr_exp[i]));
      check_eq("rr_rdata",  a_rdata, 32'h0000_0100 + 32'(i));
    end
    a_req = 3'b000;
    step();

    // Timeout on ch0: busy never rises, 8 cycles in ISSUE
    a_req = 3'b001; a_erdata = 32'hBAD0_BAD0;
    step();
    check_eq("to_rwi", 32'(a_rwi), 32'h1);
    repeat (7) step();
    check_eq("to_done_early", 32'(a_done), 32'h0);
    check_eq("to_rwi_late",   32'(a_rwi),  32'h1);
    step();
    check_eq("to_done",   32'(a_done),   32'h1);
    check_eq("to_err",    32'(a_err),    32'h1);
    check_eq("to_rdata",  a_rdata,       32'h0);
    check_eq("to_sticky", 32'(a_sticky), 32'h1);
    a_req = 3'b000;
    step();
    check_eq("to_err_clr",     32'(a_err),    32'h0);
    check_eq("to_sticky_hold", 32'(a_sticky), 32'h1);

    // Reset while in WAIT_DONE; pointer is 1 here, so ch0 winning proves it reset
    a_req = 3'b100;
    step();
    a_busy = 1'b1;
    step();
    check_eq("rs_rwi_wait", 32'(a_rwi), 32'h1);
    rst = 1'b1; a_req = 3'b000;
    step();
    rst = 1'b0;
    check_eq("rs_rwi",    32'(a_rwi),    32'h0);
    check_eq("rs_done",   32'(a_done),   32'h0);
    check_eq("rs_sticky", 32'(a_sticky), 32'h0);
    a_busy = 1'b0;
    step();
    check_eq("rs_done2",  32'(a_done),   32'h0);
    a_req = 3'b111;
    serve_a(32'h0000_0055, d, fr, ea);
    check_eq("rs_first_grant", 32'(d), 32'h1);
    a_req = 3'b000;
    step();

    // Fixed priority: ch0 and ch2 requesting, ch0 always wins
    b_addr = {32'h0000_3008, 32'h0000_3004, 32'h0000_3000};
    b_req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      serve_b(32'h0000_0200 + 32'(i), d, fr);
      check_eq("fp_done",        32'(d),        32'h1);
      check_eq("fp_freeze_wait", 32'(fr),       32'h5);
      check_eq("fp_freeze_done", 32'(b_freeze), 32'h4);
      check_eq("fp_addr",        b_eaddr,       32'h0000_3000);
    end
    b_req = 3'b000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
